// File: rtl/ipv4_tx_insert.sv
// ipv4_tx_insert: transmit-path stage between the IPv4 header generator and
// the MAC tx framer. It prepends the 20-byte header to the payload stream and
// re-aligns the payload, which ends up 4 bytes off the 8-byte output lanes.
// The realignment goes through a 4-byte carry register.
module ipv4_tx_insert #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8,
    parameter int LEN_W  = 16,
    parameter int HEAD_N = 20,
    parameter int HEAD_W = HEAD_N * 8
) (
    input  logic              clk,
    input  logic              nreset,
    // payload stream from the UDP/application side
    input  logic              app_valid_i,
    output logic              app_ready_o,
    input  logic [DATA_W-1:0] app_data_i,
    input  logic [KEEP_W-1:0] app_keep_i,
    input  logic              app_last_i,
    input  logic [LEN_W-1:0]  app_len_i,
    // header generator handshake
    output logic [LEN_W-1:0]  data_len_o,
    input  logic [HEAD_W-1:0] head_i,
    // stream towards the MAC tx framer
    output logic              mac_valid_o,
    input  logic              mac_ready_i,
    output logic [DATA_W-1:0] mac_data_o,
    output logic [KEEP_W-1:0] mac_keep_o,
    output logic              mac_last_o,
    // declared length vs. counted bytes
    output logic              len_err_o
);

    // H0 is kept only so the state encoding is stable; it behaves as IDLE.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        H0   = 3'd1,
        H1   = 3'd2,
        H2   = 3'd3,
        BODY = 3'd4,
        TAIL = 3'd5
    } state_t;

    // Header bytes 8..19; bytes 0..7 go straight from head_i to the output.
    localparam int HOLD_W = HEAD_W - 64;

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   head_q, head_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         carry_q, carry_d;
    logic [2:0]          carry_n_q, carry_n_d;
    logic                mac_valid_q, mac_valid_d;
    logic [DATA_W-1:0]   mac_data_q, mac_data_d;
    logic [KEEP_W-1:0]   mac_keep_q, mac_keep_d;
    logic                mac_last_q, mac_last_d;
    logic                len_err_q, len_err_d;

    logic                ld;
    logic                accept;
    logic [3:0]          beat_n;
    logic [2:0]          carry_n_new;
    logic [LEN_W-1:0]    cnt_total;
    logic [31:0]         low_word;
    logic [KEEP_W-1:0]   tail_keep;

    // Number of valid bytes in a beat; keep is contiguous from lane 0.
    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, k[i]};
        end
        return n;
    endfunction

    // The header generator sees the payload length without a register stage.
    assign data_len_o = app_len_i;

    // Output register may take a new beat when empty or being drained.
    assign ld          = !mac_valid_q || mac_ready_i;
    assign app_ready_o = ld && ((state_q == H2) || (state_q == BODY));
    assign accept      = app_valid_i && app_ready_o;

    // Per-beat helpers: byte count, bytes spilling into the carry, running total.
    always_comb begin
        beat_n      = popcount8(app_keep_i);
        carry_n_new = (beat_n > 4'd4) ? 3'(beat_n - 4'd4) : 3'd0;
        cnt_total   = cnt_q + LEN_W'(beat_n);
        // Lanes 0-3 of a payload-bearing beat: header tail in H2, carry in BODY.
        low_word    = (state_q == H2) ? head_q[HOLD_W-1:HOLD_W-32] : carry_q;
        case (carry_n_q)
            3'd1:    tail_keep = 8'h01;
            3'd2:    tail_keep = 8'h03;
            3'd3:    tail_keep = 8'h07;
            3'd4:    tail_keep = 8'h0f;
            default: tail_keep = 8'h00;
        endcase
    end

    // Next-state, output-register and length-check logic.
    always_comb begin
        // NOTE: every _d starts as a copy of its _q, so no path through the
        // case statement leaves a signal unassigned and no latch is inferred.
        state_d     = state_q;
        head_d      = head_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        carry_n_d   = carry_n_q;
        mac_valid_d = mac_valid_q;
        mac_data_d  = mac_data_q;
        mac_keep_d  = mac_keep_q;
        mac_last_d  = mac_last_q;
        len_err_d   = 1'b0;

        // Byte counter over accepted payload beats, compared on the last one.
        if (accept) begin
            if (app_last_i) begin
                cnt_d     = '0;
                len_err_d = (cnt_total != len_q);
            end else begin
                cnt_d = cnt_total;
            end
        end

        case (state_q)
            H1: begin
                if (ld) begin
                    mac_valid_d = 1'b1;
                    mac_data_d  = head_q[63:0];
                    mac_keep_d  = '1;
                    mac_last_d  = 1'b0;
                    state_d     = H2;
                end
            end

            H2, BODY: begin
                if (ld) begin
                    if (app_valid_i) begin
                        mac_valid_d = 1'b1;
                        mac_data_d  = {app_data_i[31:0], low_word};
                        mac_keep_d  = {app_keep_i[3:0], 4'hf};
                        carry_d     = app_data_i[63:32];
                        carry_n_d   = carry_n_new;
                        if (app_last_i && (carry_n_new == 3'd0)) begin
                            mac_last_d = 1'b1;
                            state_d    = IDLE;
                        end else if (app_last_i) begin
                            mac_last_d = 1'b0;
                            state_d    = TAIL;
                        end else begin
                            mac_last_d = 1'b0;
                            state_d    = BODY;
                        end
                    end else begin
                        // Payload underrun: bubble on the output.
                        mac_valid_d = 1'b0;
                        mac_last_d  = 1'b0;
                    end
                end
            end

            TAIL: begin
                if (ld) begin
                    mac_valid_d = 1'b1;
                    mac_data_d  = {32'd0, carry_q};
                    mac_keep_d  = tail_keep;
                    mac_last_d  = 1'b1;
                    carry_n_d   = 3'd0;
                    state_d     = IDLE;
                end
            end

            // IDLE (and the unused H0): start a packet on the first payload
            // beat without consuming it; it is consumed in H2.
            default: begin
                if (ld) begin
                    if (app_valid_i) begin
                        head_d      = head_i[HEAD_W-1:64];
                        len_d       = app_len_i;
                        cnt_d       = '0;
                        mac_valid_d = 1'b1;
                        mac_data_d  = head_i[63:0];
                        mac_keep_d  = '1;
                        mac_last_d  = 1'b0;
                        state_d     = H1;
                    end else begin
                        mac_valid_d = 1'b0;
                        mac_last_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    // All state lives in one register bank; reset drops any partial packet.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            // NOTE: the wide data/header/carry flops are reset as well, because
            // the output bus must read zero out of reset and a half-built packet
            // must never leak into the next one.
            state_q     <= IDLE;
            head_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= '0;
            carry_n_q   <= '0;
            mac_valid_q <= 1'b0;
            mac_data_q  <= '0;
            mac_keep_q  <= '0;
            mac_last_q  <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before the edge, independent of statement order.
            state_q     <= state_d;
            head_q      <= head_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            carry_n_q   <= carry_n_d;
            mac_valid_q <= mac_valid_d;
            mac_data_q  <= mac_data_d;
            mac_keep_q  <= mac_keep_d;
            mac_last_q  <= mac_last_d;
            len_err_q   <= len_err_d;
        end
    end

    assign mac_valid_o = mac_valid_q;
    assign mac_data_o  = mac_data_q;
    assign mac_keep_o  = mac_keep_q;
    assign mac_last_o  = mac_last_q;
    assign len_err_o   = len_err_q;

endmodule

// File: doc/ipv4_tx_insert.md
Name: ipv4_tx_insert

Overview:
- Transmit-path stage that sits directly downstream of the IPv4 header generator and upstream of the MAC tx framer.
- Accepts the UDP/application payload stream, drives the payload length to the header generator, and latches the 20-byte header it returns.
- Emits header plus payload as one contiguous 64-bit stream.
- The 20-byte header leaves the payload misaligned by 4 bytes on the output bus, so the block re-aligns the payload through a 4-byte carry register.

Parameters:
- DATA_W, 64, stream data width in bits (block supports 64 only).
- KEEP_W, DATA_W/8, byte-enable width.
- LEN_W, 16, payload length width.
- HEAD_N, 20, header length in bytes (fixed, no options).
- HEAD_W, HEAD_N*8, header bus width.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- app_valid_i  in  1  payload beat valid
- app_ready_o  out  1  payload beat accepted when high with app_valid_i
- app_data_i  in  DATA_W  payload; byte n on bits [8n+7:8n], byte 0 first on wire
- app_keep_i  in  KEEP_W  byte enables, contiguous from lane 0; all ones except on the last beat
- app_last_i  in  1  last payload beat
- app_len_i  in  LEN_W  payload byte count; valid with the first beat, held until it is accepted
- data_len_o  out  LEN_W  to header generator; combinational copy of app_len_i
- head_i  in  HEAD_W  header from generator; byte n on bits [8n+7:8n]; combinational from data_len_o
- mac_valid_o  out  1  output beat valid
- mac_ready_i  in  1  downstream accept
- mac_data_o  out  DATA_W  output data
- mac_keep_o  out  KEEP_W  output byte enables
- mac_last_o  out  1  last output beat
- len_err_o  out  1  one-cycle pulse: byte count seen differs from app_len_i

Behaviour:
- Clock and reset: single clock clk; reset nreset is asynchronous, active-low.
- Reset values: all outputs low, data and keep zero, FSM in IDLE, counters cleared.
- Reset mid-packet: the partial packet is dropped and no last beat is emitted. After reset the block waits for a fresh first beat.
- Output register:
  - All mac_* outputs are registered.
  - Load enable ld = !mac_valid_o | mac_ready_i.
  - The output is held stable while mac_valid_o is high and mac_ready_i is low.
- app_ready_o = ld & (state==H2 | state==BODY). It is never high in IDLE, H0, H1 or TAIL.
- FSM states: IDLE, H0, H1, H2, BODY, TAIL.
  - IDLE: when app_valid_i and ld, latch head_i and app_len_i, load output with header bytes 0-7 (keep ff), go to H1.
    - Header bytes 0-7 appear on mac_*_o one cycle after app_valid_i is first seen in IDLE.
    - The first payload beat is not consumed in this state.
  - H1 (on ld): output header bytes 8-15, keep ff, go to H2. Header bytes 16-19 stay held.
  - H2 (on ld and app_valid_i): consume the beat.
    - Output = header bytes 16-19 in lanes 0-3, payload bytes 0-3 in lanes 4-7.
    - Carry register <= payload lanes 4-7; carry count c = max(popcount(keep)-4, 0).
    - If app_last_i and c==0: keep = 4+popcount(keep), assert mac_last_o, go to IDLE.
    - If app_last_i and c>0: go to TAIL.
    - Otherwise go to BODY.
    - If app_valid_i is low, output bubbles (mac_valid_o low after the current beat drains).
  - BODY (on ld and app_valid_i): consume the beat.
    - Output = carry (4 bytes) in lanes 0-3, new payload bytes 0-3 in lanes 4-7; keep = 0f | (new keep lanes 0-3 << 4).
    - Carry <= new lanes 4-7.
    - Last-beat handling is the same as H2.
  - TAIL (on ld): output carry in lanes 0-3, keep = (1<<c)-1, mac_last_o high, go to IDLE.
  - H0 is the IDLE-to-H1 bubble-free alias and is not used; it decodes to IDLE.
- Throughput and latency:
  - Back-to-back packets run with no idle output cycle when mac_ready_i is held high.
  - The payload-to-output latency is 1 cycle for accepted beats.
- Length check:
  - A 16-bit byte counter accumulates popcount(app_keep_i) over accepted beats.
  - On the accepted last beat, len_err_o pulses for one cycle if the accumulated count differs from the latched app_len_i.
  - Framing always follows app_last_i; app_len_i only feeds the header.
- Arithmetic: the counter wraps modulo 2^16. Payload range is 1..1480 bytes; length 0 is illegal and is reported through len_err_o if it occurs.

Test Plan:
- app_len_i=8, one beat keep ff last, ready high -> 4 beats total: H[0:7], H[8:15], {P3..P0,H19..H16}, TAIL keep 0f with P7..P4 and last; len_err_o stays 0.
- app_len_i=3, one beat keep 07 -> 3 beats; third beat keep 7f with last; no TAIL.
- app_len_i=12, beats keep ff then 0f -> 4 beats; fourth beat = {P11..P4}, keep ff, last.
- 16-byte packet with mac_ready_i low for 3 cycles mid-packet -> output held stable, app_ready_o low, no byte lost or duplicated.
- app_len_i=10 declared, 8 bytes sent -> len_err_o pulses once on the last accepted beat; stream still framed by app_last_i.
- Two back-to-back 8-byte packets, then nreset pulsed during the H1 beat of a third packet -> first two packets are byte-exact with no gap; after reset all outputs are 0 and the next packet starts from header byte 0.
